// File: rtl/pwm_capture.sv
// PWM capture: measures high time and period of an asynchronous PWM input in i_clk cycles,
// published through a 16-bit Wishbone register map. Define PWM_CAPTURE_IRQ_EN to enable o_irq.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | capture disabled, counter held at 0
// ARM     | waiting for the first rise; partial period is discarded
// MEAS    | counting; fall latches high time, rise publishes results
module pwm_capture #(
   parameter int unsigned CNT_W  = 16,
   parameter logic [15:0] TO_RST = 16'hFFFF
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_wb_cyc,
   input  logic        i_wb_stb,
   input  logic        i_wb_we,
   input  logic [3:0]  i_wb_adr,
   input  logic [15:0] i_wb_data,
   output logic        o_wb_ack,
   output logic [15:0] o_wb_data,
   input  logic        i_pwm,
   output logic        o_irq
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ARM  = 2'd1;
   localparam logic [1:0] ST_MEAS = 2'd2;

   localparam logic [3:0] ADR_CTRL    = 4'd0;
   localparam logic [3:0] ADR_STATUS  = 4'd1;
   localparam logic [3:0] ADR_HIGH    = 4'd2;
   localparam logic [3:0] ADR_PERIOD  = 4'd3;
   localparam logic [3:0] ADR_TIMEOUT = 4'd4;

   logic             pwm_s1, pwm_s2, pwm_s3;
   logic             rise, fall;
   logic [1:0]       state;
   logic [CNT_W-1:0] cnt, hi_shadow, high_cnt, period_cnt;
   logic [15:0]      to_cnt, timeout_reg;
   logic             ctrl_en, ctrl_irq_v, ctrl_irq_t;
   logic             st_valid, st_ovf, st_timeout;
   logic             wb_req, wr_ctrl, wr_status, wr_to, clr;
   logic [2:0]       w1c;
   logic             cnt_max, meas_act, to_fire, publish, ovf_set;
   logic [15:0]      rd_data;

   // two-flop synchroniser, third flop for edge detection, registered pulses
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pwm_s1 <= 1'b0;
         pwm_s2 <= 1'b0;
         pwm_s3 <= 1'b0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         pwm_s1 <= i_pwm;
         pwm_s2 <= pwm_s1;
         pwm_s3 <= pwm_s2;
         rise   <= pwm_s2 & ~pwm_s3;
         fall   <= ~pwm_s2 & pwm_s3;
      end
   end

   assign wb_req    = i_wb_cyc & i_wb_stb & ~o_wb_ack;
   assign wr_ctrl   = wb_req & i_wb_we & (i_wb_adr == ADR_CTRL);
   assign wr_status = wb_req & i_wb_we & (i_wb_adr == ADR_STATUS);
   assign wr_to     = wb_req & i_wb_we & (i_wb_adr == ADR_TIMEOUT);
   assign clr       = wr_ctrl & i_wb_data[3];
   assign w1c       = wr_status ? i_wb_data[2:0] : 3'b000;

   assign cnt_max  = &cnt;
   assign meas_act = ctrl_en & (state == ST_MEAS) & ~clr;
   // timeout counts consecutive edge-free cycles; a zero limit disables it
   assign to_fire  = ctrl_en & (state != ST_IDLE) & (timeout_reg != 16'd0) &
                     (to_cnt == 16'd1) & ~rise & ~fall;
   assign publish  = meas_act & rise;
   assign ovf_set  = meas_act & ~rise & ~to_fire & cnt_max;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ctrl_en <= 1'b0;
      end else if (wr_ctrl) begin
         ctrl_en <= i_wb_data[0];
      end
   end

`ifdef PWM_CAPTURE_IRQ_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ctrl_irq_v <= 1'b0;
         ctrl_irq_t <= 1'b0;
         o_irq      <= 1'b0;
      end else begin
         if (wr_ctrl) begin
            ctrl_irq_v <= i_wb_data[1];
            ctrl_irq_t <= i_wb_data[2];
         end
         o_irq <= (st_valid & ctrl_irq_v) | (st_timeout & ctrl_irq_t);
      end
   end
`else
   assign ctrl_irq_v = 1'b0;
   assign ctrl_irq_t = 1'b0;
   assign o_irq      = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         timeout_reg <= TO_RST;
      end else if (wr_to) begin
         timeout_reg <= i_wb_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         to_cnt <= 16'd0;
      end else if (!ctrl_en || state == ST_IDLE || rise || fall || to_fire || clr ||
                   to_cnt == 16'd0) begin
         to_cnt <= timeout_reg;
      end else begin
         to_cnt <= to_cnt - 16'd1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         hi_shadow <= '0;
      end else if (!ctrl_en) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else if (clr) begin
         state     <= ST_ARM;
         cnt       <= '0;
         hi_shadow <= '0;
      end else if (to_fire) begin
         state <= ST_ARM;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               state <= ST_ARM;
               cnt   <= '0;
            end
            ST_ARM: begin
               if (rise) begin
                  state <= ST_MEAS;
                  cnt   <= CNT_W'(1);
               end
            end
            ST_MEAS: begin
               if (fall) hi_shadow <= cnt;
               if (rise) cnt <= CNT_W'(1);
               else if (!cnt_max) cnt <= cnt + CNT_W'(1);
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   // hardware set beats a same-cycle W1C; clr beats everything
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         high_cnt   <= '0;
         period_cnt <= '0;
         st_valid   <= 1'b0;
         st_ovf     <= 1'b0;
         st_timeout <= 1'b0;
      end else if (clr) begin
         high_cnt   <= '0;
         period_cnt <= '0;
         st_valid   <= 1'b0;
         st_ovf     <= 1'b0;
         st_timeout <= 1'b0;
      end else begin
         if (publish) begin
            high_cnt   <= hi_shadow;
            period_cnt <= cnt;
         end
         st_valid   <= publish | (st_valid & ~w1c[0]);
         st_ovf     <= ovf_set | (st_ovf & ~w1c[1]);
         st_timeout <= to_fire | (st_timeout & ~w1c[2]);
      end
   end

   always_comb begin
      rd_data = 16'd0;
      case (i_wb_adr)
         ADR_CTRL:    rd_data[2:0] = {ctrl_irq_t, ctrl_irq_v, ctrl_en};
         ADR_STATUS:  rd_data[2:0] = {st_timeout, st_ovf, st_valid};
         ADR_HIGH:    rd_data[CNT_W-1:0] = high_cnt;
         ADR_PERIOD:  rd_data[CNT_W-1:0] = period_cnt;
         ADR_TIMEOUT: rd_data = timeout_reg;
         default:     rd_data = 16'd0;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_wb_ack  <= 1'b0;
         o_wb_data <= 16'd0;
      end else begin
         o_wb_ack  <= wb_req;
         o_wb_data <= (wb_req & ~i_wb_we) ? rd_data : 16'd0;
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: random PWM patterns checked against an arithmetic model of
// high time / period, plus directed timeout, overflow, collision, disable and bus cases.
module tb_pwm_capture;

   localparam logic [3:0] ADR_CTRL    = 4'd0;
   localparam logic [3:0] ADR_STATUS  = 4'd1;
   localparam logic [3:0] ADR_HIGH    = 4'd2;
   localparam logic [3:0] ADR_PERIOD  = 4'd3;
   localparam logic [3:0] ADR_TIMEOUT = 4'd4;

`ifdef PWM_CAPTURE_IRQ_EN
   localparam bit IRQ_BUILD = 1'b1;
`else
   localparam bit IRQ_BUILD = 1'b0;
`endif

   logic        i_clk;
   logic        i_rst_n;
   logic        i_wb_cyc, i_wb_stb, i_wb_we;
   logic [3:0]  i_wb_adr;
   logic [15:0] i_wb_data;
   logic        o_wb_ack;
   logic [15:0] o_wb_data;
   logic        i_pwm;
   logic        o_irq;

   int n_checks = 0;
   int n_errors = 0;

   // PWM pattern source: high for pwm_hi cycles, low for pwm_lo cycles
   bit pwm_on = 1'b0;
   int pwm_hi = 40;
   int pwm_lo = 60;
   int pwm_ph = 0;

   pwm_capture dut (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_wb_cyc  (i_wb_cyc),
      .i_wb_stb  (i_wb_stb),
      .i_wb_we   (i_wb_we),
      .i_wb_adr  (i_wb_adr),
      .i_wb_data (i_wb_data),
      .o_wb_ack  (o_wb_ack),
      .o_wb_data (o_wb_data),
      .i_pwm     (i_pwm),
      .o_irq     (o_irq)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   always @(negedge i_clk) begin
      if (!pwm_on) begin
         i_pwm  = 1'b0;
         pwm_ph = 0;
      end else begin
         i_pwm  = (pwm_ph < pwm_hi);
         pwm_ph = (pwm_ph + 1 >= pwm_hi + pwm_lo) ? 0 : pwm_ph + 1;
      end
   end

   initial begin
      #980000;
      $display("FAIL watchdog expired checks=%0d", n_checks);
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // reference model: results are the driven durations, saturated to the counter width
   function automatic logic [15:0] sat16(input int v);
      return (v > 65535) ? 16'hFFFF : 16'(v);
   endfunction

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge i_clk);
   endtask

   // called at a negedge; ack must appear exactly one cycle later and last one cycle
   task automatic wb_xfer(input logic we, input logic [3:0] adr, input logic [15:0] wdat,
                          output logic [15:0] rdat);
      i_wb_cyc  = 1'b1;
      i_wb_stb  = 1'b1;
      i_wb_we   = we;
      i_wb_adr  = adr;
      i_wb_data = wdat;
      @(negedge i_clk);
      check_eq("ack_1cyc", o_wb_ack, 1);
      rdat      = o_wb_data;
      i_wb_cyc  = 1'b0;
      i_wb_stb  = 1'b0;
      i_wb_we   = 1'b0;
      @(negedge i_clk);
      check_eq("ack_drop", o_wb_ack, 0);
      check_eq("data_idle", o_wb_data, 0);
   endtask

   task automatic wb_write(input logic [3:0] adr, input logic [15:0] wdat);
      logic [15:0] dummy;
      wb_xfer(1'b1, adr, wdat, dummy);
   endtask

   task automatic rd_check(input string tag, input logic [3:0] adr, input logic [15:0] exp);
      logic [15:0] rd;
      wb_xfer(1'b0, adr, 16'd0, rd);
      check_eq(tag, rd, exp);
   endtask

   task automatic pwm_set(input int hi, input int lo);
      @(posedge i_clk);
      pwm_hi = hi;
      pwm_lo = lo;
      pwm_on = 1'b1;
      @(negedge i_clk);
   endtask

   task automatic pwm_stop();
      @(posedge i_clk);
      pwm_on = 1'b0;
      @(negedge i_clk);
   endtask

   // lands a bus access on the edge where the DUT acts on the next PWM rise
   task automatic align_to_rise();
      @(posedge i_pwm);
      repeat (3) @(negedge i_clk);
   endtask

   initial begin
      int hi, lo;
      bit got_valid;
      logic [15:0] rd;

      i_rst_n   = 1'b0;
      i_wb_cyc  = 1'b0;
      i_wb_stb  = 1'b0;
      i_wb_we   = 1'b0;
      i_wb_adr  = 4'd0;
      i_wb_data = 16'd0;

      // reset state
      wait_cyc(3);
      check_eq("rst_ack", o_wb_ack, 0);
      check_eq("rst_irq", o_irq, 0);
      check_eq("rst_data", o_wb_data, 0);
      i_rst_n = 1'b1;
      wait_cyc(2);
      rd_check("rst_timeout_reg", ADR_TIMEOUT, 16'hFFFF);
      rd_check("rst_ctrl", ADR_CTRL, 16'h0000);
      rd_check("rst_status", ADR_STATUS, 16'h0000);

      // basic measurement 40 high / 60 low
      wb_write(ADR_CTRL, 16'h0001);
      pwm_set(40, 60);
      wait_cyc(40);
      rd_check("basic_no_valid_yet", ADR_STATUS, 16'h0000);
      wait_cyc(110);
      rd_check("basic_status", ADR_STATUS, 16'h0001);
      rd_check("basic_high", ADR_HIGH, sat16(40));
      rd_check("basic_period", ADR_PERIOD, sat16(100));

      // bus behaviour: unmapped address, RO write, ctrl readback
      rd_check("adr7_read", 4'd7, 16'h0000);
      wb_write(4'd7, 16'hFFFF);
      wb_write(ADR_HIGH, 16'h1234);
      rd_check("ro_high_kept", ADR_HIGH, sat16(40));
      wb_write(ADR_CTRL, 16'h0007);
      rd_check("ctrl_readback", ADR_CTRL, IRQ_BUILD ? 16'h0007 : 16'h0001);
      wait_cyc(2);
      check_eq("irq_valid", o_irq, IRQ_BUILD ? 1 : 0);
      wb_write(ADR_CTRL, 16'h0001);

      // W1C alone, then W1C colliding with a publish
      @(posedge i_pwm);
      wait_cyc(20);
      wb_write(ADR_STATUS, 16'h0001);
      rd_check("w1c_valid", ADR_STATUS, 16'h0000);
      align_to_rise();
      wb_write(ADR_STATUS, 16'h0001);
      rd_check("w1c_vs_publish", ADR_STATUS, 16'h0001);
      align_to_rise();
      wb_write(ADR_CTRL, 16'h0009);
      rd_check("clr_high", ADR_HIGH, 16'h0000);
      rd_check("clr_period", ADR_PERIOD, 16'h0000);
      rd_check("clr_status", ADR_STATUS, 16'h0000);
      rd_check("clr_self_clear", ADR_CTRL, 16'h0001);

      // disable mid-period, results held, re-enable needs two rises
      wait_cyc(250);
      rd_check("dis_pre_high", ADR_HIGH, sat16(40));
      @(posedge i_pwm);
      wait_cyc(20);
      wb_write(ADR_CTRL, 16'h0000);
      pwm_set(20, 30);
      wb_write(ADR_STATUS, 16'h0001);
      wait_cyc(200);
      rd_check("dis_high_held", ADR_HIGH, sat16(40));
      rd_check("dis_period_held", ADR_PERIOD, sat16(100));
      rd_check("dis_status", ADR_STATUS, 16'h0000);
      @(posedge i_pwm);
      wait_cyc(5);
      wb_write(ADR_CTRL, 16'h0001);
      wait_cyc(70);
      rd_check("reen_one_rise_status", ADR_STATUS, 16'h0000);
      rd_check("reen_one_rise_high", ADR_HIGH, sat16(40));
      wait_cyc(40);
      rd_check("reen_status", ADR_STATUS, 16'h0001);
      rd_check("reen_high", ADR_HIGH, sat16(20));
      rd_check("reen_period", ADR_PERIOD, sat16(50));

      // random patterns against the model
      wb_write(ADR_TIMEOUT, 16'd1234);
      for (int it = 0; it < 6; it++) begin
         hi = int'($urandom_range(100, 1));
         lo = int'($urandom_range(100, 1));
         pwm_set(hi, lo);
         wait_cyc(3 * (hi + lo) + 10);
         wb_write(ADR_STATUS, 16'h0001);
         got_valid = 1'b0;
         for (int k = 0; k < 150 && !got_valid; k++) begin
            wb_xfer(1'b0, ADR_STATUS, 16'd0, rd);
            if (rd[0]) got_valid = 1'b1;
            else wait_cyc(2);
         end
         check_eq("rnd_valid_seen", got_valid, 1);
         rd_check("rnd_high", ADR_HIGH, sat16(hi));
         rd_check("rnd_period", ADR_PERIOD, sat16(hi + lo));
         rd_check("rnd_status", ADR_STATUS, 16'h0001);
      end

      // asynchronous reset while a read is being acknowledged
      i_wb_cyc = 1'b1;
      i_wb_stb = 1'b1;
      i_wb_we  = 1'b0;
      i_wb_adr = ADR_TIMEOUT;
      #7;
      i_rst_n = 1'b0;
      #1;
      check_eq("midrst_ack", o_wb_ack, 0);
      check_eq("midrst_data", o_wb_data, 0);
      check_eq("midrst_irq", o_irq, 0);
      i_wb_cyc = 1'b0;
      i_wb_stb = 1'b0;
      @(negedge i_clk);
      i_rst_n = 1'b1;
      wait_cyc(1);
      rd_check("midrst_timeout_reg", ADR_TIMEOUT, 16'hFFFF);
      rd_check("midrst_ctrl", ADR_CTRL, 16'h0000);
      rd_check("midrst_high", ADR_HIGH, 16'h0000);
      rd_check("midrst_period", ADR_PERIOD, 16'h0000);
      wait_cyc(300);
      rd_check("midrst_idle_status", ADR_STATUS, 16'h0000);

      // timeout with the input held low
      pwm_stop();
      wait_cyc(5);
      wb_write(ADR_TIMEOUT, 16'd50);
      wb_write(ADR_CTRL, 16'h0005);
      wait_cyc(46);
      rd_check("to_not_yet", ADR_STATUS, 16'h0000);
      wait_cyc(6);
      rd_check("to_status", ADR_STATUS, 16'h0004);
      check_eq("to_irq", o_irq, IRQ_BUILD ? 1 : 0);
      wb_write(ADR_CTRL, 16'h0000);
      wb_write(ADR_STATUS, 16'h0004);
      rd_check("to_w1c", ADR_STATUS, 16'h0000);
      check_eq("to_irq_clear", o_irq, 0);

      // overflow: 70000-cycle period, timeout disabled
      wb_write(ADR_TIMEOUT, 16'd0);
      wb_write(ADR_CTRL, 16'h0009);
      pwm_set(1000, 69000);
      wait_cyc(70020);
      rd_check("ovf_period", ADR_PERIOD, sat16(70000));
      rd_check("ovf_high", ADR_HIGH, sat16(1000));
      rd_check("ovf_status", ADR_STATUS, 16'h0003);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
